// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: state encodings and register constants.
// No logic and no latency; backpressure is not applicable.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stage enable/flush outputs exchanged between the pipeline datapath and its controller.
// No latency; the bundle carries no flow control of its own.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             mem_wb_flush;
    logic             mem_err;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    // Datapath side: supplies hazard information, consumes enables/flushes.
    modport master (
        output id_rs, id_rt, ex_mem_read, ex_rd, ex_branch_taken, mem_req, mem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
        input  mem_err, halted, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, ex_mem_read, ex_rd, ex_branch_taken, mem_req, mem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
        output mem_err, halted, stall_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use detector: flags an ID instruction reading the destination of a load in EX (r0 never hazards).
// Purely combinational, zero latency; no backpressure.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       loaduse
);

    assign loaduse = ex_mem_read && (ex_rd != REG_ZERO) &&
                     ((ex_rd == id_rs) || (ex_rd == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch squash, memory freeze with timeout halt.
// Outputs are combinational from state and inputs (zero latency); a slow data memory freezes everything upstream of WB.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int WAIT_W  = 8,
    parameter int CNT_W   = 32
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);

    localparam logic [WAIT_W-1:0] TMO = WAIT_W'(TIMEOUT);

    state_t             state, state_nx;
    logic [WAIT_W-1:0]  wait_cnt, wait_nx;
    logic               mem_err_r, err_nx;
    logic [CNT_W-1:0]   stall_cnt_r;
    logic               loaduse;
    logic               freeze;

    logic pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
    logic if_id_fl_c, id_ex_fl_c, ex_mem_fl_c, mem_wb_fl_c;

    hazard_detect u_hazard (
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .ex_mem_read (bus.ex_mem_read),
        .ex_rd       (bus.ex_rd),
        .loaduse     (loaduse)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            mem_err_r   <= 1'b0;
            stall_cnt_r <= '0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_nx;
            mem_err_r <= err_nx;
            if (!pc_en_c && (state != ST_HALT) && (stall_cnt_r != '1))
                stall_cnt_r <= stall_cnt_r + 1'b1;
        end
    end

    always_comb begin
        state_nx    = state;
        wait_nx     = wait_cnt;
        err_nx      = mem_err_r;
        freeze      = 1'b0;
        pc_en_c     = 1'b0;
        if_id_en_c  = 1'b0;
        id_ex_en_c  = 1'b0;
        ex_mem_en_c = 1'b0;
        mem_wb_en_c = 1'b0;
        if_id_fl_c  = 1'b0;
        id_ex_fl_c  = 1'b0;
        ex_mem_fl_c = 1'b0;
        mem_wb_fl_c = 1'b0;

        case (state)
            ST_RUN: begin
                freeze = bus.mem_req && !bus.mem_ready;
                if (freeze) begin
                    state_nx = ST_MEM_WAIT;
                    wait_nx  = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                // A dropped mem_req without ready is ignored: only ready ends the wait.
                freeze = !bus.mem_ready;
                if (bus.mem_ready) begin
                    state_nx = ST_RUN;
                    wait_nx  = '0;
                end else if (wait_cnt == TMO) begin
                    state_nx = ST_HALT;
                    err_nx   = 1'b1;
                end else begin
                    wait_nx = wait_cnt + 1'b1;
                end
            end
            ST_HALT: ;
            default: state_nx = ST_RUN;
        endcase

        if (state != ST_HALT) begin
            if (freeze) begin
                mem_wb_en_c = 1'b1;
                mem_wb_fl_c = 1'b1;
            end else begin
                pc_en_c     = 1'b1;
                if_id_en_c  = 1'b1;
                id_ex_en_c  = 1'b1;
                ex_mem_en_c = 1'b1;
                mem_wb_en_c = 1'b1;
                // The dependent instruction is squashed by a taken branch, so no bubble is needed.
                if (bus.ex_branch_taken) begin
                    if_id_fl_c = 1'b1;
                    id_ex_fl_c = 1'b1;
                end else if (loaduse) begin
                    pc_en_c    = 1'b0;
                    if_id_en_c = 1'b0;
                    id_ex_fl_c = 1'b1;
                end
            end
        end
    end

    assign bus.pc_en        = pc_en_c     && !rst;
    assign bus.if_id_en     = if_id_en_c  && !rst;
    assign bus.id_ex_en     = id_ex_en_c  && !rst;
    assign bus.ex_mem_en    = ex_mem_en_c && !rst;
    assign bus.mem_wb_en    = mem_wb_en_c && !rst;
    assign bus.if_id_flush  = if_id_fl_c  && !rst;
    assign bus.id_ex_flush  = id_ex_fl_c  && !rst;
    assign bus.ex_mem_flush = ex_mem_fl_c && !rst;
    assign bus.mem_wb_flush = mem_wb_fl_c && !rst;
    assign bus.halted       = (state == ST_HALT) && !rst;
    assign bus.mem_err      = mem_err_r;
    assign bus.stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard scenarios plus randomized traffic against a cycle-level reference model.
module tb_pipeline_ctrl;

    localparam int TMO   = 4;
    localparam int CW    = 6;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    pipeline_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_ctrl #(.TIMEOUT(TMO), .WAIT_W(8), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    wire [4:0] en_v = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en};
    wire [3:0] fl_v = {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush};

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                         input logic [4:0] rd, input logic br, input logic req, input logic rdy);
        bus.id_rs           = rs;
        bus.id_rt           = rt;
        bus.ex_mem_read     = mr;
        bus.ex_rd           = rd;
        bus.ex_branch_taken = br;
        bus.mem_req         = req;
        bus.mem_ready       = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(7, 7, 1, 7, 1, 1, 0);
        @(negedge clk);
        n_cmp++;
        if ({en_v, fl_v, bus.halted} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: en=%b fl=%b halted=%b, need all 0", en_v, fl_v, bus.halted);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (bus.stall_cnt !== 0 || bus.mem_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_regs: stall_cnt=%0d mem_err=%b, need 0/0", bus.stall_cnt, bus.mem_err);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_loaduse();
        do_reset();
        drive(3, 5, 1, 5, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (en_v !== 5'b00111 || fl_v !== 4'b0100) begin
            n_bad++;
            $display("FAIL loaduse_bubble: en=%b fl=%b, need 00111/0100", en_v, fl_v);
        end
        tick();
        drive(6, 7, 0, 5, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (en_v !== 5'b11111 || fl_v !== 4'b0000 || bus.stall_cnt !== 1) begin
            n_bad++;
            $display("FAIL loaduse_after: en=%b fl=%b cnt=%0d, need 11111/0000/1", en_v, fl_v, bus.stall_cnt);
        end
        tick();
    endtask

    task automatic test_r0();
        do_reset();
        drive(0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (en_v !== 5'b11111 || fl_v !== 4'b0000) begin
            n_bad++;
            $display("FAIL r0_exempt: en=%b fl=%b, need 11111/0000", en_v, fl_v);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (bus.stall_cnt !== 0) begin
            n_bad++;
            $display("FAIL r0_cnt: stall_cnt=%0d, need 0", bus.stall_cnt);
        end
        tick();
    endtask

    task automatic test_branch_over_loaduse();
        do_reset();
        drive(9, 2, 1, 9, 1, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (en_v !== 5'b11111 || fl_v !== 4'b1100) begin
            n_bad++;
            $display("FAIL branch_prio: en=%b fl=%b, need 11111/1100", en_v, fl_v);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (bus.stall_cnt !== 0) begin
            n_bad++;
            $display("FAIL branch_cnt: stall_cnt=%0d, need 0", bus.stall_cnt);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            // Load-use and branch inputs must be ignored while frozen.
            drive(4, 4, 1, 4, c[0], 1, 0);
            @(negedge clk);
            n_cmp++;
            if (en_v !== 5'b00001 || fl_v !== 4'b0001) begin
                n_bad++;
                $display("FAIL mem_freeze_%0d: en=%b fl=%b, need 00001/0001", c, en_v, fl_v);
            end
            tick();
        end
        drive(1, 2, 0, 3, 0, 1, 1);
        @(negedge clk);
        n_cmp++;
        if (en_v !== 5'b11111 || fl_v !== 4'b0000) begin
            n_bad++;
            $display("FAIL mem_ready_cycle: en=%b fl=%b, need 11111/0000", en_v, fl_v);
        end
        tick();
        drive(1, 2, 0, 3, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (en_v !== 5'b11111 || bus.stall_cnt !== 3 || bus.halted !== 1'b0) begin
            n_bad++;
            $display("FAIL mem_after: en=%b cnt=%0d halted=%b, need 11111/3/0", en_v, bus.stall_cnt, bus.halted);
        end
        tick();
        // Single-cycle access never stalls.
        drive(1, 2, 0, 3, 0, 1, 1);
        @(negedge clk);
        n_cmp++;
        if (en_v !== 5'b11111 || fl_v !== 4'b0000) begin
            n_bad++;
            $display("FAIL mem_one_cycle: en=%b fl=%b, need 11111/0000", en_v, fl_v);
        end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 0; c <= TMO; c++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            @(negedge clk);
            n_cmp++;
            if (en_v !== 5'b00001 || bus.halted !== 1'b0) begin
                n_bad++;
                $display("FAIL timeout_wait_%0d: en=%b halted=%b, need 00001/0", c, en_v, bus.halted);
            end
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 0, 1, 1, 1);
            @(negedge clk);
            n_cmp++;
            if ({en_v, fl_v} !== 9'b0 || bus.halted !== 1'b1 || bus.mem_err !== 1'b1 ||
                bus.stall_cnt !== TMO + 1) begin
                n_bad++;
                $display("FAIL timeout_halt_%0d: en=%b fl=%b halted=%b err=%b cnt=%0d, need 0/0/1/1/%0d",
                         c, en_v, fl_v, bus.halted, bus.mem_err, bus.stall_cnt, TMO + 1);
            end
            tick();
        end
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (bus.halted !== 1'b0 || bus.mem_err !== 1'b0 || en_v !== 5'b11111) begin
            n_bad++;
            $display("FAIL halt_exit: halted=%b err=%b en=%b, need 0/0/11111", bus.halted, bus.mem_err, en_v);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        drive(0, 0, 0, 0, 0, 1, 0);
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({en_v, fl_v, bus.halted} !== 10'b0) begin
            n_bad++;
            $display("FAIL rst_wait_outputs: en=%b fl=%b halted=%b, need all 0", en_v, fl_v, bus.halted);
        end
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (en_v !== 5'b11111 || fl_v !== 4'b0000 || bus.stall_cnt !== 0 || bus.mem_err !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_wait_after: en=%b fl=%b cnt=%0d err=%b, need 11111/0000/0/0",
                     en_v, fl_v, bus.stall_cnt, bus.mem_err);
        end
        tick();
    endtask

    task automatic test_random();
        int       m_wait = 0;
        bit       m_halt = 0;
        bit       m_err  = 0;
        int       m_cnt  = 0;
        logic [4:0] rs, rt, rd, e_en;
        logic [3:0] e_fl;
        logic       mr, br, req, rdy, r, lu, frz, e_halt;
        logic [16:0] exp_v, got_v;
        for (int i = 0; i < 3000; i++) begin
            r   = (i == 0) || ($urandom_range(0, 99) == 0);
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 3));
            mr  = ($urandom_range(0, 1) == 1);
            br  = ($urandom_range(0, 4) == 0);
            req = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 9) < 4);
            rst = r;
            drive(rs, rt, mr, rd, br, req, rdy);
            @(negedge clk);

            lu     = mr && (rd != 0) && (rd == rs || rd == rt);
            frz    = 1'b0;
            e_halt = 1'b0;
            if (r || m_halt) begin
                e_en   = 5'b00000;
                e_fl   = 4'b0000;
                e_halt = !r;
            end else begin
                frz = !rdy && (m_wait > 0 || req);
                if (frz)      begin e_en = 5'b00001; e_fl = 4'b0001; end
                else if (br)  begin e_en = 5'b11111; e_fl = 4'b1100; end
                else if (lu)  begin e_en = 5'b00111; e_fl = 4'b0100; end
                else          begin e_en = 5'b11111; e_fl = 4'b0000; end
            end
            exp_v = {e_en, e_fl, m_err, e_halt, 6'(m_cnt)};
            got_v = {en_v, fl_v, bus.mem_err, bus.halted, bus.stall_cnt};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_bad++;
                $display("FAIL random_cycle_%0d: got en=%b fl=%b err=%b halt=%b cnt=%0d, need en=%b fl=%b err=%b halt=%b cnt=%0d",
                         i, en_v, fl_v, bus.mem_err, bus.halted, bus.stall_cnt,
                         e_en, e_fl, m_err, e_halt, m_cnt);
            end

            if (r) begin
                m_wait = 0; m_halt = 0; m_err = 0; m_cnt = 0;
            end else if (!m_halt) begin
                if (!e_en[4] && m_cnt < CMAX) m_cnt++;
                if (!frz)              m_wait = 0;
                else if (m_wait == TMO) begin m_halt = 1; m_err = 1; end
                else                   m_wait++;
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        test_reset();
        test_loaduse();
        test_r0();
        test_branch_over_loaduse();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage 32-bit MIPS pipeline. Drives per-stage enable/flush for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. Resolves three hazard sources:
- load-use hazards
- taken branches resolved in EX
- multi-cycle data-memory accesses in MEM, with a timeout that halts the core.

It also keeps a stall-cycle performance counter.

Parameters:
- TIMEOUT, 64: max consecutive MEM_WAIT cycles before error; must be ≥1 and < 2^WAIT_W.
- WAIT_W, 8: width of the wait counter.
- CNT_W, 32: width of the stall_cnt performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of the instruction in EX
- ex_branch_taken  in  1  branch in EX resolved taken; PC mux selects target this cycle
- mem_req  in  1  instruction in MEM accesses data memory
- mem_ready  in  1  data memory completes access this cycle
- pc_en  out  1  PC load enable
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register load enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  clear register to 0 at next edge; flush overrides en
- mem_err  out  1  sticky: memory timeout occurred
- halted  out  1  controller is in HALT
- stall_cnt  out  CNT_W  cycles with pc_en=0 outside HALT, saturating

Behaviour:
- State register, encoded RUN=0, MEM_WAIT=1, HALT=2. All outputs are combinational from state plus current inputs. Registered items: state, wait_cnt, mem_err, stall_cnt.

Reset:
- While rst=1: state←RUN, wait_cnt←0, mem_err←0, stall_cnt←0.
- Outputs during rst: all en=0, all flush=0, halted=0.
- Reset from any state, including mid-MEM_WAIT or HALT, takes effect at the next edge.

Output modes (en=1 / flush=0 unless listed):
- Normal: all en=1, all flush=0.
- Freeze (memory stall): pc_en, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_en=1 and mem_wb_flush=1, so a bubble enters WB. Branch and load-use inputs are ignored in this mode.
- Branch flush: if_id_flush=1, id_ex_flush=1. PC loads the target.
- Load-use: loaduse = ex_mem_read & (ex_rd≠0) & (ex_rd==id_rs | ex_rd==id_rt). Outputs: pc_en=0, if_id_en=0, id_ex_flush=1. One-cycle bubble, then the condition clears naturally.

Output priority:
- HALT: all en=0, all flush=0.
- Otherwise: freeze > branch flush > load-use > normal.
- Branch wins over load-use because the dependent instruction is squashed anyway.

RUN state:
- freeze_cond = mem_req & ~mem_ready.
- If freeze_cond: use freeze outputs, go to MEM_WAIT, wait_cnt←1.
- Otherwise: stay in RUN. A single-cycle access (mem_req & mem_ready) causes no stall.

MEM_WAIT state:
- Freeze outputs apply whenever mem_ready=0.
- If mem_ready=1: use normal/branch/load-use outputs by priority, go to RUN, wait_cnt←0.
- Else if wait_cnt==TIMEOUT: go to HALT, mem_err←1.
- Else: wait_cnt←wait_cnt+1.
- mem_req dropping while mem_ready=0 is a protocol violation; the controller stays in MEM_WAIT.

HALT state:
- Terminal; left only via rst. halted=1, mem_err stays 1.

stall_cnt:
- Increments at each edge where pc_en=0 and state≠HALT and rst=0.
- Saturates at all-ones.

Decomposition:
- Shared include/package pipe_ctrl_defs: state encodings (ST_RUN, ST_MEM_WAIT, ST_HALT) and REG_ZERO=5'd0.
- One natural sub-module: hazard_detect, purely combinational. Inputs id_rs, id_rt, ex_mem_read, ex_rd; output loaduse. It is reused later for forwarding checks.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rt=5 in RUN → pc_en=0, if_id_en=0, id_ex_flush=1 for one cycle; stall_cnt 0→1.
- r0 exemption: ex_mem_read=1, ex_rd=0, id_rs=0 → normal outputs, no stall.
- Branch beats load-use: ex_branch_taken=1 together with a load-use match → if_id_flush=1, id_ex_flush=1, pc_en=1; stall_cnt unchanged.
- Memory wait, 3-cycle access: mem_req=1 with mem_ready low for 3 cycles then high → freeze for 3 cycles with mem_wb_flush=1. On the ready cycle, normal outputs and state back to RUN. stall_cnt=3.
- Timeout with TIMEOUT=4: mem_req=1, mem_ready held 0 → HALT entered after wait_cnt reaches 4. Then mem_err=1, halted=1, all en=0. Late mem_ready=1 has no effect.
- Reset in MEM_WAIT: rst=1 for one cycle mid-wait → state RUN, mem_err=0, stall_cnt=0, all en=0 during rst; normal operation afterwards.
